ram_write_fmap: RTL and testbench

Write-side companion to the 5x5 window reader: accepts a raster-ordered stream of convolution results, quantises each to 8 bits, and writes it into a single-port feature-map block RAM at address row*IMG_W+col. One frame is IMG_H*IMG_W pixels, framed by `restart` and a one-cycle `Stop` pulse. It sits between the convolution MAC datapath and the feature-map RAM that the next layer's window reader consumes.

---
 rtl/fmap_pkg.sv | 31 +++
 rtl/fmap_quant.sv | 48 ++++
 rtl/ram_write_fmap.sv | 153 +++++++++++++++
 tb/tb_ram_write_fmap.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fmap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fmap_pkg
//  Description : Shared types and constants for the feature-map write path:
//                FSM state encoding, default geometry, and the quantiser
//                output range for both RELU_EN settings.
//  Revision    : 1.0 - initial release
// ============================================================================
package fmap_pkg;

  // Frame-writer control states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fmap_state_t;

  // Default feature-map geometry
  localparam int c_img_w  = 24;
  localparam int c_img_h  = 24;
  localparam int c_addr_w = 10;

  // Signed quantiser range (ReLU left to a downstream layer)
  localparam int c_q_min_signed = -128;
  localparam int c_q_max_signed = 127;

  // Unsigned quantiser range (ReLU fused into quantisation)
  localparam int c_q_min_relu = 0;
  localparam int c_q_max_relu = 255;

endpackage : fmap_pkg
`default_nettype wire

// File: rtl/fmap_quant.sv
`default_nettype none
// ============================================================================
//  Module      : fmap_quant
//  Description : Combinational quantiser from an IN_W-bit signed convolution
//                result to an 8-bit feature-map value. Arithmetic right shift
//                by SHIFT, then saturation. With RELU_EN defined the output is
//                unsigned 0..255 (ReLU fused); otherwise it is signed
//                -128..127 in two's complement.
//  Revision    : 1.0 - initial release
// ============================================================================
module fmap_quant
  import fmap_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int SHIFT = 4
) (
  input  logic signed [IN_W-1:0] in_data,
  output logic        [7:0]      q
);

  logic signed [IN_W-1:0] w_shifted;
  logic signed [31:0]     w_wide;

  // >>> on a signed operand floors toward -inf, matching the intended rounding
  assign w_shifted = in_data >>> SHIFT;
  // Size cast of a signed value sign-extends, so comparisons below are signed
  assign w_wide    = 32'(w_shifted);

  // Clamp the shifted value into the 8-bit output range
  always_comb begin
    q = w_wide[7:0];
`ifdef RELU_EN
    if (w_wide < c_q_min_relu) begin
      q = 8'(c_q_min_relu);
    end else if (w_wide > c_q_max_relu) begin
      q = 8'(c_q_max_relu);
    end
`else
    if (w_wide < c_q_min_signed) begin
      q = 8'(c_q_min_signed);
    end else if (w_wide > c_q_max_signed) begin
      q = 8'(c_q_max_signed);
    end
`endif
  end

endmodule : fmap_quant
`default_nettype wire

// File: rtl/ram_write_fmap.sv
`default_nettype none
// ============================================================================
//  Module      : ram_write_fmap
//  Description : Write side of the feature-map RAM. Accepts a raster-ordered
//                stream of convolution results, quantises each to 8 bits and
//                issues one port-A write per accepted pixel at
//                row*IMG_W+col. A frame is started/restarted by restart and
//                ends with a one-cycle Stop pulse on the final write.
//                Build option: RELU_EN (fused ReLU, unsigned output) selects
//                the quantiser range inside fmap_quant.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_write_fmap
  import fmap_pkg::*;
#(
  parameter int IMG_W  = c_img_w,
  parameter int IMG_H  = c_img_h,
  parameter int IN_W   = 16,
  parameter int SHIFT  = 4,
  parameter int ADDR_W = c_addr_w
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   restart,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in_data,
  output logic                   wea,
  output logic [ADDR_W-1:0]      addra,
  output logic [7:0]             dina,
  output logic [4:0]             row,
  output logic [4:0]             col,
  output logic                   busy,
  output logic                   Stop
);

  localparam logic [4:0] c_col_last = 5'(IMG_W - 1);
  localparam logic [4:0] c_row_last = 5'(IMG_H - 1);

  fmap_state_t         r_state;
  fmap_state_t         w_state_nxt;
  logic [4:0]          r_row;
  logic [4:0]          r_col;
  logic [ADDR_W-1:0]   r_addr_cnt;
  logic                r_wea;
  logic [ADDR_W-1:0]   r_addra;
  logic [7:0]          r_dina;
  logic                r_stop;
  logic                w_ready;
  logic                w_accept;
  logic                w_clear;
  logic                w_last;
  logic                w_end_frame;
  logic [7:0]          w_q;

  fmap_quant #(
    .IN_W  (IN_W),
    .SHIFT (SHIFT)
  ) u_quant (
    .in_data (in_data),
    .q       (w_q)
  );

  assign w_last      = (r_row == c_row_last) && (r_col == c_col_last);
  assign w_end_frame = w_accept && w_last;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, handshake and counter-clear decode; restart beats a sample
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (en && restart) begin
          w_state_nxt = RUN;
          w_clear     = 1'b1;
        end
      end
      RUN: begin
        if (en && restart) begin
          w_clear = 1'b1;
        end else begin
          w_ready  = en;
          w_accept = en && in_valid;
          if (w_accept && w_last) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Raster position and running address; the address is counted, not multiplied
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row      <= '0;
      r_col      <= '0;
      r_addr_cnt <= '0;
    end else if (w_clear || w_end_frame) begin
      r_row      <= '0;
      r_col      <= '0;
      r_addr_cnt <= '0;
    end else if (w_accept) begin
      if (r_col == c_col_last) begin
        r_col <= '0;
        r_row <= r_row + 5'd1;
      end else begin
        r_col <= r_col + 5'd1;
      end
      r_addr_cnt <= r_addr_cnt + ADDR_W'(1);
    end
  end

  // Registered RAM port-A write; address/data hold between writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wea   <= 1'b0;
      r_addra <= '0;
      r_dina  <= '0;
      r_stop  <= 1'b0;
    end else begin
      r_wea  <= w_accept;
      r_stop <= w_end_frame;
      if (w_accept) begin
        r_addra <= r_addr_cnt;
        r_dina  <= w_q;
      end
    end
  end

  assign in_ready = w_ready;
  assign wea      = r_wea;
  assign addra    = r_addra;
  assign dina     = r_dina;
  assign row      = r_row;
  assign col      = r_col;
  assign busy     = (r_state == RUN);
  assign Stop     = r_stop;

endmodule : ram_write_fmap
`default_nettype wire

// File: tb/tb_ram_write_fmap.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_write_fmap
//  Description : Self-checking bench for ram_write_fmap. A pixel-index model
//                predicts every write, position and handshake each cycle;
//                directed phases pin quantiser values, throttling, restart
//                and asynchronous reset with literal expectations.
//                Honours RELU_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_write_fmap;

  localparam int IMG_W  = 24;
  localparam int IMG_H  = 24;
  localparam int IN_W   = 16;
  localparam int SHIFT  = 4;
  localparam int ADDR_W = 10;
  localparam int NPIX   = IMG_W * IMG_H;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   en = 1'b0;
  logic                   restart = 1'b0;
  logic                   in_valid = 1'b0;
  logic signed [IN_W-1:0] in_data = '0;
  logic                   in_ready;
  logic                   wea;
  logic [ADDR_W-1:0]      addra;
  logic [7:0]             dina;
  logic [4:0]             row;
  logic [4:0]             col;
  logic                   busy;
  logic                   Stop;

  int n_vec = 0;
  int n_err = 0;

  ram_write_fmap #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .IN_W   (IN_W),
    .SHIFT  (SHIFT),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .restart  (restart),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .wea      (wea),
    .addra    (addra),
    .dina     (dina),
    .row      (row),
    .col      (col),
    .busy     (busy),
    .Stop     (Stop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference quantiser: floor division by 2**SHIFT, then clamp
  function automatic logic [7:0] model_q(input int x);
    int d;
    int t;
    d = 1 << SHIFT;
    if (x >= 0) t = x / d;
    else        t = -(((-x) + d - 1) / d);
`ifdef RELU_EN
    if (t < 0)   t = 0;
    if (t > 255) t = 255;
`else
    if (t < -128) t = -128;
    if (t > 127)  t = 127;
`endif
    return t[7:0];
  endfunction

  // Model state: whether a frame is open and the index of the next pixel
  bit          m_in_frame = 1'b0;
  int          m_p = 0;
  logic        e_wea = 1'b0;
  logic        e_stop = 1'b0;
  int          e_addra = 0;
  logic [7:0]  e_dina = '0;

  // Single compare process: check against last prediction, then predict next edge
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_wea",      32'(wea), 0);
      chk("rst_addra",    32'(addra), 0);
      chk("rst_dina",     32'(dina), 0);
      chk("rst_row",      32'(row), 0);
      chk("rst_col",      32'(col), 0);
      chk("rst_busy",     32'(busy), 0);
      chk("rst_stop",     32'(Stop), 0);
      m_in_frame = 1'b0;
      m_p        = 0;
      e_wea      = 1'b0;
      e_stop     = 1'b0;
      e_addra    = 0;
      e_dina     = '0;
    end else begin
      bit rdy;
      bit acc;
      rdy = m_in_frame && en && !restart;
      acc = rdy && in_valid;
      chk("wea",      32'(wea), 32'(e_wea));
      chk("stop",     32'(Stop), 32'(e_stop));
      chk("addra",    32'(addra), e_addra);
      chk("dina",     32'(dina), 32'(e_dina));
      chk("busy",     32'(busy), 32'(m_in_frame));
      chk("row",      32'(row), m_p / IMG_W);
      chk("col",      32'(col), m_p % IMG_W);
      chk("in_ready", 32'(in_ready), 32'(rdy));
      e_wea  = acc;
      e_stop = acc && (m_p == NPIX - 1);
      if (acc) begin
        e_addra = m_p;
        e_dina  = model_q(int'(in_data));
        m_p++;
        if (m_p == NPIX) begin
          m_p        = 0;
          m_in_frame = 1'b0;
        end
      end
      if (en && restart) begin
        m_in_frame = 1'b1;
        m_p        = 0;
      end
    end
  end

  task automatic drive(input logic e, input logic r, input logic v, input logic signed [IN_W-1:0] d);
    en       = e;
    restart  = r;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  logic signed [IN_W-1:0] qv[4];
  logic [7:0]             ql[4];

  initial begin
`ifdef RELU_EN
    qv[0] = -16'sd17;   ql[0] = 8'd0;
    qv[1] = 16'sd5000;  ql[1] = 8'd255;
    qv[2] = 16'sd1600;  ql[2] = 8'd100;
    qv[3] = 16'sd4095;  ql[3] = 8'd255;
`else
    qv[0] = -16'sd32768; ql[0] = 8'h80;
    qv[1] = -16'sd17;    ql[1] = 8'hFE;
    qv[2] = 16'sd2047;   ql[2] = 8'h7F;
    qv[3] = 16'sd2048;   ql[3] = 8'h7F;
`endif

    // Reset
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 16'sd5);  // valid in IDLE must be ignored

    // Quantiser corner values
    drive(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, qv[i]);
      chk("quant_wea", 32'(wea), 1);
      chk("quant_dina", 32'(dina), 32'(ql[i]));
    end

    // Full frame of k*16 with throttling at pixel 300
    drive(1'b1, 1'b1, 1'b0, '0);
    for (int k = 0; k < NPIX; k++) begin
      if (k == 300) begin
        chk("thr_row", 32'(row), 12);
        chk("thr_col", 32'(col), 12);
        for (int c = 0; c < 10; c++) begin
          drive(1'b0, 1'b0, (c % 2) == 0, 16'(k * 16));
          chk("thr_wea", 32'(wea), 0);
        end
        chk("thr_row_hold", 32'(row), 12);
        chk("thr_col_hold", 32'(col), 12);
      end
      drive(1'b1, 1'b0, 1'b1, 16'(k * 16));
    end
    chk("frame_stop", 32'(Stop), 1);
    chk("frame_last_addr", 32'(addra), 575);
    chk("frame_busy_drop", 32'(busy), 0);
    drive(1'b1, 1'b0, 1'b0, '0);

    // Restart at pixel 100 with a sample presented
    drive(1'b1, 1'b1, 1'b0, '0);
    for (int k = 0; k < 100; k++) drive(1'b1, 1'b0, 1'b1, 16'(k * 16));
    drive(1'b1, 1'b1, 1'b1, 16'sh7FFF);
    chk("rs_drop_wea", 32'(wea), 0);
    for (int k = 0; k < NPIX; k++) begin
      drive(1'b1, 1'b0, 1'b1, 16'(k * 16));
      if (k == 0) chk("rs_first_addr", 32'(addra), 0);
      if (k == NPIX - 2) chk("rs_no_early_stop", 32'(Stop), 0);
    end
    chk("rs_stop", 32'(Stop), 1);
    chk("rs_last_addr", 32'(addra), 575);

    // Randomised traffic
    drive(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 2500; i++) begin
      drive(($urandom % 10) != 0, ($urandom % 400) == 0,
            ($urandom % 10) < 7, 16'($urandom));
    end

    // Asynchronous reset with a write in flight at pixel 50
    drive(1'b1, 1'b1, 1'b0, '0);
    for (int k = 0; k < 50; k++) drive(1'b1, 1'b0, 1'b1, 16'(k * 16));
    en       = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'sd800;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_wea",      32'(wea), 0);
    chk("ar_stop",     32'(Stop), 0);
    chk("ar_busy",     32'(busy), 0);
    chk("ar_in_ready", 32'(in_ready), 0);
    chk("ar_addra",    32'(addra), 0);
    chk("ar_dina",     32'(dina), 0);
    chk("ar_row",      32'(row), 0);
    chk("ar_col",      32'(col), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, 16'sd100);
      chk("ar_idle_stop", 32'(Stop), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_ram_write_fmap
`default_nettype wire
